// File: rtl/cube2_hub75_pkg.sv
// Shared HUB75 definitions: default row-address width, RGB bit positions
// within the 6-bit pixel bus and the receiver state encoding.
package cube2_hub75_pkg;

   localparam int HUB75_ROW_BITS = 4;

   // Pixel bus ordering is {b1,g1,r1,b0,g0,r0}
   localparam int RGB_R0 = 0;
   localparam int RGB_G0 = 1;
   localparam int RGB_B0 = 2;
   localparam int RGB_R1 = 3;
   localparam int RGB_G1 = 4;
   localparam int RGB_B1 = 5;
   localparam int HUB75_RGB_W = RGB_B1 + 1;

   typedef enum logic {
      ST_SHIFT = 1'b0,
      ST_DRAIN = 1'b1
   } rx_state_e;

endpackage

// File: rtl/hub75_rx_sync.sv
// Two-flop synchronizer for a bus of asynchronous panel pins, plus a
// one-cycle rising-edge pulse per bit derived from the synchronized copy.
module hub75_rx_sync #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] async_i,
   output logic [W-1:0] sync_o,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;
   logic [W-1:0] prev_q;

   // Synchronizer chain plus one delayed copy for edge detection
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-input receiver: captures shifted pixels into a ping-pong line
// buffer and drains each latched row as an addressed write stream.
// Optional macro HUB75_RX_OE_COUNT_EN adds an output-enable cycle counter.
module hub75_rx
   import cube2_hub75_pkg::*;
#(
   parameter int PANEL_W  = 32,
   parameter int ROW_BITS = HUB75_ROW_BITS
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 hub75_clk,
   input  logic                                 hub75_lat,
   input  logic                                 hub75_oe_n,
   input  logic [ROW_BITS-1:0]                  hub75_row,
   input  logic [5:0]                           hub75_rgb,
   output logic                                 wr_valid,
   input  logic                                 wr_ready,
   output logic [ROW_BITS+$clog2(PANEL_W)-1:0]  wr_addr,
   output logic [5:0]                           wr_data,
   output logic                                 err_overflow,
   output logic                                 err_latch_busy,
   input  logic                                 clr_err
`ifdef HUB75_RX_OE_COUNT_EN
   ,
   output logic [15:0]                          oe_cycles,
   output logic                                 oe_valid
`endif
);

   localparam int COL_W   = $clog2(PANEL_W);
   localparam int CNT_W   = COL_W + 1;
   localparam int ADDR_W  = ROW_BITS + COL_W;
   localparam int SYNC_W  = HUB75_RGB_W + ROW_BITS + 3;
   localparam int IDX_ROW = HUB75_RGB_W;
   localparam int IDX_CLK = HUB75_RGB_W + ROW_BITS;
   localparam int IDX_LAT = IDX_CLK + 1;
   localparam int IDX_OE  = IDX_CLK + 2;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PANEL_W);

   logic [SYNC_W-1:0]   pins_s;
   logic [SYNC_W-1:0]   sync_s;
   logic [SYNC_W-1:0]   rise_s;
   logic [5:0]          rgb_s;
   logic [ROW_BITS-1:0] row_s;
   logic                clk_rise_s;
   logic                lat_rise_s;
   logic                oe_n_s;
   logic                unused_s;

   assign pins_s = {hub75_oe_n, hub75_lat, hub75_clk, hub75_row, hub75_rgb};

   hub75_rx_sync #(
      .W (SYNC_W)
   ) u_sync (
      .clk_i   (clk),
      .rst_i   (reset),
      .async_i (pins_s),
      .sync_o  (sync_s),
      .rise_o  (rise_s)
   );

   assign rgb_s      = sync_s[HUB75_RGB_W-1:0];
   assign row_s      = sync_s[IDX_ROW +: ROW_BITS];
   assign clk_rise_s = rise_s[IDX_CLK];
   assign lat_rise_s = rise_s[IDX_LAT];
   assign oe_n_s     = sync_s[IDX_OE];
   assign unused_s   = ^{rise_s[IDX_CLK-1:0], rise_s[IDX_OE], sync_s[IDX_LAT:IDX_CLK], oe_n_s};

   rx_state_e           state_q, state_d;
   logic [CNT_W-1:0]    col_cnt_q, col_cnt_d;
   logic                bank_q, bank_d;
   logic [ROW_BITS-1:0] row_q, row_d;
   logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0]    drain_idx_q, drain_idx_d;
   logic                wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [5:0]          wr_data_q, wr_data_d;
   logic                err_ovf_q, err_ovf_d;
   logic                err_busy_q, err_busy_d;

   logic [5:0]          buf_q [2][PANEL_W];
   logic                buf_we_s;
   logic [COL_W-1:0]    buf_wcol_s;
   logic                ovf_set_s;
   logic                busy_set_s;
   logic                rd_bank_s;
   logic [COL_W-1:0]    rd_col_s;
   logic [5:0]          rd_data_s;

   // bank_q is the bank being shifted into; the drain always reads the other one
   assign rd_bank_s = ~bank_q;
   assign rd_col_s  = drain_idx_q[COL_W-1:0];
   assign rd_data_s = buf_q[rd_bank_s][rd_col_s];

   // Next-state logic for shift capture, latch handling, drain stream and error flags
   always_comb begin
      state_d     = state_q;
      col_cnt_d   = col_cnt_q;
      bank_d      = bank_q;
      row_d       = row_q;
      drain_cnt_d = drain_cnt_q;
      drain_idx_d = drain_idx_q;
      wr_valid_d  = wr_valid_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      buf_we_s    = 1'b0;
      buf_wcol_s  = '0;
      ovf_set_s   = 1'b0;
      busy_set_s  = 1'b0;

      if (clk_rise_s) begin
         if (col_cnt_q == FULL_CNT) begin
            ovf_set_s = 1'b1;
         end else begin
            buf_we_s   = 1'b1;
            buf_wcol_s = col_cnt_q[COL_W-1:0];
            col_cnt_d  = col_cnt_q + CNT_W'(1);
         end
      end else begin
         buf_we_s = 1'b0;
      end

      case (state_q)
         ST_SHIFT: begin
            // A same-cycle shift edge is counted into the row being latched
            if (lat_rise_s) begin
               state_d     = ST_DRAIN;
               row_d       = row_s;
               drain_cnt_d = col_cnt_d;
               drain_idx_d = '0;
               col_cnt_d   = '0;
               bank_d      = ~bank_q;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DRAIN: begin
            busy_set_s = lat_rise_s;
            if (!wr_valid_q || wr_ready) begin
               if (drain_idx_q < drain_cnt_q) begin
                  wr_valid_d  = 1'b1;
                  wr_addr_d   = {row_q, rd_col_s};
                  wr_data_d   = rd_data_s;
                  drain_idx_d = drain_idx_q + CNT_W'(1);
               end else begin
                  wr_valid_d = 1'b0;
                  state_d    = ST_SHIFT;
               end
            end else begin
               wr_valid_d = wr_valid_q;
            end
         end
         default: begin
            state_d    = ST_SHIFT;
            wr_valid_d = 1'b0;
         end
      endcase

      // A same-cycle error set wins over clr_err
      err_ovf_d  = (err_ovf_q & ~clr_err) | ovf_set_s;
      err_busy_d = (err_busy_q & ~clr_err) | busy_set_s;
   end

   // Control and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_SHIFT;
         col_cnt_q   <= '0;
         bank_q      <= 1'b0;
         row_q       <= '0;
         drain_cnt_q <= '0;
         drain_idx_q <= '0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 6'd0;
         err_ovf_q   <= 1'b0;
         err_busy_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_cnt_q   <= col_cnt_d;
         bank_q      <= bank_d;
         row_q       <= row_d;
         drain_cnt_q <= drain_cnt_d;
         drain_idx_q <= drain_idx_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         err_ovf_q   <= err_ovf_d;
         err_busy_q  <= err_busy_d;
      end
   end

   // Line buffer storage; contents are only read after being written
   always_ff @(posedge clk) begin
      if (buf_we_s) begin
         buf_q[bank_q][buf_wcol_s] <= rgb_s;
      end
   end

   assign wr_valid       = wr_valid_q;
   assign wr_addr        = wr_addr_q;
   assign wr_data        = wr_data_q;
   assign err_overflow   = err_ovf_q;
   assign err_latch_busy = err_busy_q;

`ifdef HUB75_RX_OE_COUNT_EN
   logic [15:0] oe_cnt_q, oe_cnt_d;
   logic [15:0] oe_cycles_q, oe_cycles_d;
   logic        oe_valid_q, oe_valid_d;

   // Saturating count of enabled cycles, published and restarted on each latch edge
   always_comb begin
      oe_cnt_d    = oe_cnt_q;
      oe_cycles_d = oe_cycles_q;
      oe_valid_d  = 1'b0;
      if (lat_rise_s) begin
         oe_cycles_d = oe_cnt_q;
         oe_valid_d  = 1'b1;
         oe_cnt_d    = 16'd0;
      end else if (!oe_n_s && (oe_cnt_q != 16'hFFFF)) begin
         oe_cnt_d = oe_cnt_q + 16'd1;
      end else begin
         oe_cnt_d = oe_cnt_q;
      end
   end

   // Output-enable counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         oe_cnt_q    <= 16'd0;
         oe_cycles_q <= 16'd0;
         oe_valid_q  <= 1'b0;
      end else begin
         oe_cnt_q    <= oe_cnt_d;
         oe_cycles_q <= oe_cycles_d;
         oe_valid_q  <= oe_valid_d;
      end
   end

   assign oe_cycles = oe_cycles_q;
   assign oe_valid  = oe_valid_q;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Directed self-checking bench for hub75_rx (PANEL_W=32, ROW_BITS=4).
module tb_hub75_rx;

   localparam int PW = 32;
   localparam int RB = 4;
   localparam int AW = 9;

   logic          clk        = 1'b0;
   logic          reset      = 1'b1;
   logic          hub75_clk  = 1'b0;
   logic          hub75_lat  = 1'b0;
   logic          hub75_oe_n = 1'b1;
   logic [RB-1:0] hub75_row  = '0;
   logic [5:0]    hub75_rgb  = 6'd0;
   logic          clr_err    = 1'b0;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [5:0]    wr_data;
   logic          err_overflow;
   logic          err_latch_busy;
`ifdef HUB75_RX_OE_COUNT_EN
   logic [15:0]   oe_cycles;
   logic          oe_valid;
   int            oe_pulses = 0;
   logic [15:0]   oe_last   = 16'd0;
`endif

   logic          ready_fix = 1'b1;
   logic          ready_tog = 1'b0;
   logic          phase     = 1'b0;
   int            checks    = 0;
   int            failures  = 0;
   logic [AW-1:0] qa[$];
   logic [5:0]    qd[$];
   logic          stall_prev = 1'b0;
   logic [AW-1:0] pa = '0;
   logic [5:0]    pd = 6'd0;

   always #5 clk = ~clk;
   always @(posedge clk) phase <= ~phase;
   assign wr_ready = ready_tog ? phase : ready_fix;

   hub75_rx #(
      .PANEL_W  (PW),
      .ROW_BITS (RB)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .hub75_clk      (hub75_clk),
      .hub75_lat      (hub75_lat),
      .hub75_oe_n     (hub75_oe_n),
      .hub75_row      (hub75_row),
      .hub75_rgb      (hub75_rgb),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .err_overflow   (err_overflow),
      .err_latch_busy (err_latch_busy),
      .clr_err        (clr_err)
`ifdef HUB75_RX_OE_COUNT_EN
      ,
      .oe_cycles      (oe_cycles),
      .oe_valid       (oe_valid)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Records transfers (valid & ready ahead of the next rising edge) and checks stall stability
   always @(negedge clk) begin
      if (stall_prev && !reset) begin
         chk("stall_valid", {31'd0, wr_valid}, 32'd1);
         chk("stall_addr", {23'd0, wr_addr}, {23'd0, pa});
         chk("stall_data", {26'd0, wr_data}, {26'd0, pd});
      end
      if (wr_valid && wr_ready && !reset) begin
         qa.push_back(wr_addr);
         qd.push_back(wr_data);
      end
      stall_prev <= wr_valid && !wr_ready && !reset;
      pa <= wr_addr;
      pd <= wr_data;
`ifdef HUB75_RX_OE_COUNT_EN
      if (oe_valid) begin
         oe_pulses <= oe_pulses + 1;
         oe_last   <= oe_cycles;
      end
`endif
   end

   task automatic set_ready(input logic tog, input logic fix);
      @(posedge clk);
      #1;
      ready_tog = tog;
      ready_fix = fix;
   endtask

   task automatic shift_px(input logic [5:0] v);
      @(negedge clk);
      hub75_rgb = v;
      repeat (2) @(negedge clk);
      hub75_clk = 1'b1;
      repeat (3) @(negedge clk);
      hub75_clk = 1'b0;
      @(negedge clk);
   endtask

   task automatic latch_row(input logic [RB-1:0] r);
      @(negedge clk);
      hub75_row = r;
      repeat (2) @(negedge clk);
      hub75_lat = 1'b1;
      repeat (3) @(negedge clk);
      hub75_lat = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle(input int n);
      int k;
      k = 0;
      while ((qa.size() < n || wr_valid) && k < 3000) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("wait_bound", {31'd0, (k < 3000)}, 32'd1);
   endtask

   task automatic chk_seq(input string tag, input logic [RB-1:0] r, input int n, input logic [5:0] x);
      chk({tag, "_count"}, qa.size(), n);
      for (int i = 0; i < n && i < qa.size(); i++) begin
         chk({tag, "_addr"}, {23'd0, qa[i]}, {23'd0, r, 5'(i)});
         chk({tag, "_data"}, {26'd0, qd[i]}, {26'd0, 6'(i) ^ x});
      end
   endtask

   initial begin
      int k;
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'd0, wr_valid}, 32'd0);
      chk("rst_addr", {23'd0, wr_addr}, 32'd0);
      chk("rst_data", {26'd0, wr_data}, 32'd0);
      chk("rst_ovf", {31'd0, err_overflow}, 32'd0);
      chk("rst_busy", {31'd0, err_latch_busy}, 32'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Latch with nothing shifted: no writes at all
      latch_row(4'd2);
      repeat (20) @(negedge clk);
      chk("empty_count", qa.size(), 0);
      chk("empty_valid", {31'd0, wr_valid}, 32'd0);

      // Full row, always ready
      for (int i = 0; i < PW; i++) shift_px(6'(i));
      latch_row(4'd5);
      wait_idle(32);
      chk_seq("basic", 4'd5, 32, 6'h00);
      chk("basic_ovf", {31'd0, err_overflow}, 32'd0);

      // Same row, ready toggling every cycle
      qa.delete(); qd.delete();
      set_ready(1'b1, 1'b1);
      for (int i = 0; i < PW; i++) shift_px(6'(i));
      latch_row(4'd5);
      wait_idle(32);
      set_ready(1'b0, 1'b1);
      chk_seq("stall", 4'd5, 32, 6'h00);

      // 33 shift edges: last pixel dropped, overflow flagged then cleared
      qa.delete(); qd.delete();
      for (int i = 0; i < PW + 1; i++) shift_px(6'(i));
      latch_row(4'd5);
      wait_idle(32);
      repeat (20) @(negedge clk);
      chk_seq("ovf", 4'd5, 32, 6'h00);
      chk("ovf_flag", {31'd0, err_overflow}, 32'd1);
      chk("ovf_busy", {31'd0, err_latch_busy}, 32'd0);
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("ovf_clr", {31'd0, err_overflow}, 32'd0);

      // Latch while a drain is still blocked: second latch ignored
      qa.delete(); qd.delete();
      set_ready(1'b0, 1'b0);
      for (int i = 0; i < PW; i++) shift_px(6'(i) ^ 6'h15);
      latch_row(4'd3);
      for (int i = 0; i < PW; i++) shift_px(6'(i) ^ 6'h2A);
      latch_row(4'd4);
      repeat (5) @(negedge clk);
      chk("busy_flag", {31'd0, err_latch_busy}, 32'd1);
      chk("busy_hold_count", qa.size(), 0);
      chk("busy_hold_valid", {31'd0, wr_valid}, 32'd1);
      set_ready(1'b0, 1'b1);
      wait_idle(32);
      repeat (60) @(negedge clk);
      chk_seq("busy", 4'd3, 32, 6'h15);

      // Reset in the middle of a drain
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst2_ovf", {31'd0, err_overflow}, 32'd0);
      chk("rst2_busy", {31'd0, err_latch_busy}, 32'd0);
      qa.delete(); qd.delete();
      set_ready(1'b0, 1'b0);
      for (int i = 0; i < PW; i++) shift_px(6'(i));
      latch_row(4'd6);
      set_ready(1'b0, 1'b1);
      k = 0;
      while (qa.size() < 10 && k < 2000) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("mid_bound", {31'd0, (k < 2000)}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, wr_valid}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      chk_seq("mid", 4'd6, 10, 6'h00);
      chk("mid_valid", {31'd0, wr_valid}, 32'd0);
      chk("mid_ovf", {31'd0, err_overflow}, 32'd0);
      chk("mid_busy", {31'd0, err_latch_busy}, 32'd0);

`ifdef HUB75_RX_OE_COUNT_EN
      // 100 enabled cycles between two latch edges
      k = oe_pulses;
      latch_row(4'd0);
      repeat (10) @(negedge clk);
      chk("oe_first", {16'd0, oe_last}, 32'd0);
      @(negedge clk);
      hub75_oe_n = 1'b0;
      repeat (100) @(negedge clk);
      hub75_oe_n = 1'b1;
      repeat (10) @(negedge clk);
      latch_row(4'd0);
      repeat (10) @(negedge clk);
      chk("oe_pulses", oe_pulses - k, 2);
      chk("oe_cycles", {16'd0, oe_last}, 32'd100);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 SHALL have parameter PANEL_W, default 32, number of columns shifted per row (power of two, 8..128).
REQ-002 SHALL have parameter ROW_BITS, default 4, width of the HUB75 row address.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports hub75_clk, hub75_lat, hub75_oe_n, input, 1 each, asynchronous panel shift clock, latch and output enable (active-low).
REQ-006 SHALL have port hub75_row, input, ROW_BITS, asynchronous row address.
REQ-007 SHALL have port hub75_rgb, input, 6, {b1,g1,r1,b0,g0,r0}, asynchronous pixel data.
REQ-008 SHALL have ports wr_valid (output, 1), wr_ready (input, 1), wr_addr (output, ROW_BITS+log2(PANEL_W)), wr_data (output, 6); the captured-pixel write stream.
REQ-009 SHALL have ports err_overflow and err_latch_busy, output, 1 each; sticky error flags.
REQ-010 SHALL have port clr_err, input, 1; clears both error flags.

Function
REQ-011 SHALL pass all hub75_* inputs through a 2-flop synchronizer, then detect rising edges of hub75_clk and hub75_lat from the synchronized copies (capture latency 3 clk cycles from pin edge).
REQ-012 SHALL, on each synchronized hub75_clk rising edge in SHIFT, write the synchronized hub75_rgb into a PANEL_W x 6 line buffer at col_cnt and increment col_cnt.
REQ-013 SHALL, when col_cnt has reached PANEL_W and a further shift edge arrives, drop the pixel, hold col_cnt, and set err_overflow.
REQ-014 SHALL, on a hub75_lat rising edge in SHIFT, capture hub75_row into row_q, reset col_cnt to 0 and enter DRAIN; a latch with col_cnt = 0 enters DRAIN with zero entries and returns to SHIFT the next cycle.
REQ-015 SHALL in DRAIN present entries 0..n-1 in order (n = columns received, max PANEL_W), wr_addr = {row_q, column}, wr_data = buffered pixel.
REQ-016 SHALL hold wr_valid, wr_addr, wr_data stable while wr_valid=1 and wr_ready=0; a transfer occurs when both are 1 on a clk edge.
REQ-017 SHALL return to SHIFT the cycle after the last DRAIN transfer.
REQ-018 SHALL drain into a second bank (ping-pong line buffer) so shift edges arriving during DRAIN are accepted into the other bank without loss.
REQ-019 SHALL, on a latch edge while DRAIN is still active, ignore that latch (keep the current drain, do not swap banks) and set err_latch_busy.
REQ-020 SHALL give clr_err priority below a same-cycle error set (the flag remains 1).
REQ-021 SHALL ignore hub75_oe_n in the base configuration.

Reset
REQ-022 SHALL on reset: state SHIFT, col_cnt 0, active bank 0, row_q 0, wr_valid 0, wr_addr 0, wr_data 0, both error flags 0, synchronizers 0.
REQ-023 SHALL, on reset mid-DRAIN, abandon the drain immediately with no further transfers.

Configuration
REQ-024 SHALL, with macro HUB75_RX_OE_COUNT_EN defined, add output oe_cycles (16 bits) and output oe_valid (1 bit); count clk cycles with synchronized hub75_oe_n=0 between consecutive latch edges (saturating at 0xFFFF), publish the count with a one-cycle oe_valid pulse on each latch edge, then restart from 0.
REQ-025 SHALL, without the macro, omit oe_cycles, oe_valid and the counter logic entirely.

Structure
REQ-026 SHALL take ROW_BITS default, the RGB bit-ordering constants and the DRAIN/SHIFT state encoding from the shared package cube2_hub75_pkg.
REQ-027 SHALL place the synchronizer and edge detection in sub-module hub75_rx_sync (2-flop sync plus rising-edge pulse per input bit).

Verification
REQ-028 SHALL cover: 32 shift edges with rgb = column[5:0], latch with row=5, wr_ready=1 -> 32 writes, wr_addr 0xA0..0xBF, wr_data 0x00..0x1F.
REQ-029 SHALL cover: same stimulus with wr_ready toggling 1/0 each cycle -> identical 32-write sequence, outputs stable while stalled.
REQ-030 SHALL cover: 33 shift edges then latch -> err_overflow=1, exactly 32 writes; clr_err -> err_overflow=0.
REQ-031 SHALL cover: wr_ready=0, latch row 3, shift 32 more pixels, latch row 4 -> err_latch_busy=1; after wr_ready=1 only row-3 writes appear.
REQ-032 SHALL cover: reset asserted after 10 of 32 drain transfers -> wr_valid=0 within the reset cycle, no further writes, err flags 0.
REQ-033 SHALL cover (HUB75_RX_OE_COUNT_EN): oe_n low for 100 clk cycles between two latches -> oe_valid pulse with oe_cycles=100.
